reset_seq: RTL and testbench
============================

# reset_seq

Power-on and soft-reset sequencer for the Laser310 core. It releases the memory, video and CPU reset domains in a fixed order, with tick-timed hold intervals and readiness handshakes. It sits between the board reset and the subsystem reset inputs, and also lets the OSD/keyboard restart only the CPU or hold it in reset while a ROM/cassette image downloads.

## Interface
Parameters:
- PRESCALE_W, 6: prescaler width; one tick every 2^PRESCALE_W clocks.
- HOLD_TICKS, 65536: ticks all domains are held in reset after SYS_RESET_N.
- GAP_TICKS, 1024: ticks between video release and the ROM-wait check.
- SOFT_TICKS, 4096: ticks the CPU is held for a soft reset.
- CNT_W, 17: tick-counter width; must hold max(HOLD,GAP,SOFT)−1.

Ports:
- CLK  in  1  system clock.
- SYS_RESET_N  in  1  reset; one clock; synchronous, active-low.
- SOFT_RST_REQ  in  1  level/pulse request for a CPU-only reset.
- SDRAM_READY  in  1  memory controller init done.
- ROM_LOAD_BUSY  in  1  image download in progress.
- MEM_RESET_N  out  1  memory domain reset, active-low.
- VIDEO_RESET_N  out  1  video domain reset, active-low.
- CPU_RESET_N  out  1  CPU domain reset, active-low.
- BUSY  out  1  high whenever the state is not RUN.
- SEQ_STATE  out  3  current state encoding.

## Operation
- States (SEQ_STATE encoding):
  - ASSERT=0
  - MEM_WAIT=1
  - VID_GAP=2
  - ROM_WAIT=3
  - RUN=4
  - SOFT=5
  - Codes 6 and 7 are illegal and go to ASSERT on the next clock.
- Timebase:
  - PRESCALE_W-bit prescaler plus CNT_W-bit tick counter.
  - Both counters clear on every state transition, so timing is deterministic.
  - Tick = prescaler all-ones.
- Transitions:
  - ASSERT: after HOLD_TICKS ticks → MEM_WAIT.
  - MEM_WAIT: when SDRAM_READY=1 → VID_GAP.
  - VID_GAP: after GAP_TICKS ticks → ROM_WAIT.
  - ROM_WAIT: when ROM_LOAD_BUSY=0 → RUN.
  - RUN: SOFT_RST_REQ=1 → SOFT; else if ROM_LOAD_BUSY=1 → ROM_WAIT.
  - SOFT: after SOFT_TICKS ticks → ROM_WAIT.
- Output decode:
  - MEM_RESET_N=1 in all states except ASSERT.
  - VIDEO_RESET_N=1 in VID_GAP, ROM_WAIT, RUN and SOFT.
  - CPU_RESET_N=1 only in RUN.
  - BUSY = !RUN.
- Outputs are registered and decoded from next-state, so they change on the same edge as SEQ_STATE.
- Priority:
  - SYS_RESET_N low overrides everything.
  - In RUN, SOFT_RST_REQ beats ROM_LOAD_BUSY.
- Requests:
  - SOFT_RST_REQ outside RUN is ignored, not latched.
  - SOFT_RST_REQ held high across SOFT→ROM_WAIT→RUN retriggers SOFT one cycle after RUN is entered.
- SDRAM_READY dropping after MEM_WAIT is ignored.

## Timing
- Reset: while SYS_RESET_N=0 at a clock edge, on that edge:
  - state ← ASSERT;
  - counters ← 0;
  - MEM/VIDEO/CPU_RESET_N ← 0, BUSY ← 1, SEQ_STATE ← 0.
- Reset mid-sequence (any state) restarts from ASSERT with full HOLD_TICKS.
- Timed state of N ticks lasts exactly N·2^PRESCALE_W clocks. It exits on the edge where tick=1 and count=N−1.
- Handshake states with the condition already true at entry last exactly 1 clock.
- Power-on to CPU release, with inputs already ready: (HOLD+GAP)·2^P + 2 clocks.
- Counters never wrap inside a state; the tick count stops at its exit value.

## Test plan
All scenarios use PRESCALE_W=2, HOLD=8, GAP=4, SOFT=2.
- Power-on, SDRAM_READY=1, ROM_LOAD_BUSY=0, SYS_RESET_N released → MEM_RESET_N rises 32 clocks later, VIDEO_RESET_N at 33, CPU_RESET_N and BUSY=0 at 50; SEQ_STATE walks 0,1,2,3,4.
- SDRAM_READY held low 100 clocks after ASSERT ends → stays in state 1 with VIDEO/CPU_RESET_N=0; releases VIDEO_RESET_N 1 clock after READY rises.
- In RUN, 1-clock SOFT_RST_REQ → CPU_RESET_N low next edge for exactly 8 clocks, then state 3 for 1 clock, then RUN; MEM/VIDEO_RESET_N stay 1.
- In RUN, ROM_LOAD_BUSY high 20 clocks, same cycle as SOFT_RST_REQ → SOFT first (8 clocks), then ROM_WAIT until busy falls, then RUN 1 clock later.
- SYS_RESET_N pulsed low 1 clock during VID_GAP → all outputs 0 at that edge; full 32-clock ASSERT repeated.
- SEQ_STATE forced to 7 → returns to 0 next clock with all resets asserted.

Source files
------------

// File: rtl/reset_seq.sv
// reset_seq: power-on and soft-reset sequencer for the Laser310 core.
// Releases the memory, video and CPU reset domains in a fixed order using a
// prescaled tick timebase and two readiness handshakes (SDRAM init and ROM
// image download). A CPU-only soft reset can be requested while running.

module reset_seq #(
    parameter int PRESCALE_W = 6,      // one tick every 2^PRESCALE_W clocks
    parameter int HOLD_TICKS = 65536,  // ticks all domains held after SYS_RESET_N
    parameter int GAP_TICKS  = 1024,   // ticks from video release to ROM-wait check
    parameter int SOFT_TICKS = 4096,   // ticks the CPU is held for a soft reset
    parameter int CNT_W      = 17      // must hold max(HOLD,GAP,SOFT)-1
) (
    input  logic       CLK,
    input  logic       SYS_RESET_N,
    input  logic       SOFT_RST_REQ,
    input  logic       SDRAM_READY,
    input  logic       ROM_LOAD_BUSY,
    output logic       MEM_RESET_N,
    output logic       VIDEO_RESET_N,
    output logic       CPU_RESET_N,
    output logic       BUSY,
    output logic [2:0] SEQ_STATE
);

    typedef enum logic [2:0] {
        ST_ASSERT   = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_VID_GAP  = 3'd2,
        ST_ROM_WAIT = 3'd3,
        ST_RUN      = 3'd4,
        ST_SOFT     = 3'd5
    } state_t;

    // Tick index on which each timed state exits.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_TICKS - 1);

    // Raw 3-bit state register so the illegal codes 6 and 7 are representable
    // and can be recovered from; the enum view is used for decoding.
    logic [2:0]            state_q;
    logic [PRESCALE_W-1:0] presc_q;
    logic [CNT_W-1:0]      ticks_q;
    state_t                cur_state;
    state_t                nxt_state;
    logic                  tick;

    assign cur_state = state_t'(state_q);
    assign tick      = &presc_q;
    assign SEQ_STATE = state_q;

    // Next-state selection from the current state, timebase and handshakes.
    always_comb begin
        // NOTE: default assignment first so every path drives nxt_state and no latch is inferred.
        nxt_state = cur_state;
        case (cur_state)
            ST_ASSERT:   if (tick && ticks_q == HOLD_LAST) nxt_state = ST_MEM_WAIT;
            ST_MEM_WAIT: if (SDRAM_READY)                  nxt_state = ST_VID_GAP;
            ST_VID_GAP:  if (tick && ticks_q == GAP_LAST)  nxt_state = ST_ROM_WAIT;
            ST_ROM_WAIT: if (!ROM_LOAD_BUSY)               nxt_state = ST_RUN;
            ST_RUN: begin
                // A soft reset request wins over a new download starting.
                if (SOFT_RST_REQ)       nxt_state = ST_SOFT;
                else if (ROM_LOAD_BUSY) nxt_state = ST_ROM_WAIT;
            end
            ST_SOFT:     if (tick && ticks_q == SOFT_LAST) nxt_state = ST_ROM_WAIT;
            default:                                       nxt_state = ST_ASSERT;
        endcase
    end

    // State, timebase and reset outputs; outputs decode nxt_state so they move with SEQ_STATE.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!SYS_RESET_N) begin
            state_q       <= ST_ASSERT;
            presc_q       <= '0;
            ticks_q       <= '0;
            MEM_RESET_N   <= 1'b0;
            VIDEO_RESET_N <= 1'b0;
            CPU_RESET_N   <= 1'b0;
            BUSY          <= 1'b1;
        end else begin
            state_q <= nxt_state;
            // Timebase restarts on every transition so each state's duration is exact.
            if (nxt_state != cur_state) begin
                presc_q <= '0;
                ticks_q <= '0;
            end else begin
                presc_q <= presc_q + PRESCALE_W'(1);
                // Saturate so a long handshake wait never wraps the tick count.
                if (tick && ticks_q != '1) ticks_q <= ticks_q + CNT_W'(1);
            end
            MEM_RESET_N   <= (nxt_state != ST_ASSERT);
            VIDEO_RESET_N <= (nxt_state inside {ST_VID_GAP, ST_ROM_WAIT, ST_RUN, ST_SOFT});
            CPU_RESET_N   <= (nxt_state == ST_RUN);
            BUSY          <= (nxt_state != ST_RUN);
        end
    end

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed plus randomized stimulus for reset_seq, compared
// every clock against a clock-countdown reference model of the sequencer.

module tb_reset_seq;

    localparam int P  = 2;
    localparam int H  = 8;
    localparam int G  = 4;
    localparam int S  = 2;
    localparam int CW = 4;
    localparam int TK = 1 << P;  // clocks per tick

    logic       CLK = 1'b0;
    logic       SYS_RESET_N = 1'b0;
    logic       SOFT_RST_REQ = 1'b0;
    logic       SDRAM_READY = 1'b0;
    logic       ROM_LOAD_BUSY = 1'b0;
    logic       MEM_RESET_N;
    logic       VIDEO_RESET_N;
    logic       CPU_RESET_N;
    logic       BUSY;
    logic [2:0] SEQ_STATE;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state code and clocks left in a timed state.
    int m_state = 0;
    int m_left  = H * TK;

    reset_seq #(
        .PRESCALE_W(P),
        .HOLD_TICKS(H),
        .GAP_TICKS (G),
        .SOFT_TICKS(S),
        .CNT_W     (CW)
    ) dut (
        .CLK          (CLK),
        .SYS_RESET_N  (SYS_RESET_N),
        .SOFT_RST_REQ (SOFT_RST_REQ),
        .SDRAM_READY  (SDRAM_READY),
        .ROM_LOAD_BUSY(ROM_LOAD_BUSY),
        .MEM_RESET_N  (MEM_RESET_N),
        .VIDEO_RESET_N(VIDEO_RESET_N),
        .CPU_RESET_N  (CPU_RESET_N),
        .BUSY         (BUSY),
        .SEQ_STATE    (SEQ_STATE)
    );

    always #5 CLK = ~CLK;

    function automatic int timed_clocks(input int s);
        case (s)
            0:       return H * TK;
            2:       return G * TK;
            5:       return S * TK;
            default: return 0;
        endcase
    endfunction

    function automatic void go(input int s);
        m_state = s;
        m_left  = timed_clocks(s);
    endfunction

    // One clock edge of the reference model, given the inputs seen at that edge.
    function automatic void model_step(input logic r, input logic s, input logic rd, input logic b);
        if (!r) go(0);
        else begin
            case (m_state)
                0:       if (m_left == 1) go(1); else m_left--;
                1:       if (rd) go(2);
                2:       if (m_left == 1) go(3); else m_left--;
                3:       if (!b) go(4);
                4:       if (s) go(5); else if (b) go(3);
                5:       if (m_left == 1) go(3); else m_left--;
                default: go(0);
            endcase
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("SEQ_STATE",     32'(SEQ_STATE),     32'(m_state));
        chk("MEM_RESET_N",   32'(MEM_RESET_N),   32'(m_state != 0));
        chk("VIDEO_RESET_N", 32'(VIDEO_RESET_N), 32'(m_state inside {2, 3, 4, 5}));
        chk("CPU_RESET_N",   32'(CPU_RESET_N),   32'(m_state == 4));
        chk("BUSY",          32'(BUSY),          32'(m_state != 4));
    endtask

    // Drive inputs on the falling edge, advance the model at the rising edge, check just after.
    task automatic step(input logic r, input logic s, input logic rd, input logic b);
        @(negedge CLK);
        SYS_RESET_N   = r;
        SOFT_RST_REQ  = s;
        SDRAM_READY   = rd;
        ROM_LOAD_BUSY = b;
        @(posedge CLK);
        model_step(r, s, rd, b);
        #1;
        compare_all();
    endtask

    initial begin
        int mem_at, vid_at, cpu_at, soft_cnt, rom_cnt, assert_cnt, guard;
        logic rs, sr, rd, bz;

        // Reset held with random side inputs: everything asserted.
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));

        // Power-on with both handshakes already satisfied.
        mem_at = 0; vid_at = 0; cpu_at = 0;
        for (int i = 1; i <= 200 && cpu_at == 0; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            if (MEM_RESET_N   && mem_at == 0) mem_at = i;
            if (VIDEO_RESET_N && vid_at == 0) vid_at = i;
            if (CPU_RESET_N)                  cpu_at = i;
        end
        chk("mem_release_clk",   32'(mem_at), 32'(H * TK));
        chk("video_release_clk", 32'(vid_at), 32'(H * TK + 1));
        chk("cpu_release_clk",   32'(cpu_at), 32'((H + G) * TK + 2));

        // One-clock soft reset request while running.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        soft_cnt = 1; rom_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            if (SEQ_STATE == 3'd5) soft_cnt++;
            if (SEQ_STATE == 3'd3) rom_cnt++;
        end
        chk("soft_hold_clks",    32'(soft_cnt), 32'(S * TK));
        chk("soft_romwait_clks", 32'(rom_cnt),  32'd1);

        // Soft request and download start on the same cycle: soft wins, then wait for download.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)  step(1'b1, 1'b0, 1'b1, 1'b0);

        // SDRAM_READY held low for 100 clocks after ASSERT ends.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < H * TK + 100; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("mem_wait_state", 32'(SEQ_STATE),     32'd1);
        chk("mem_wait_video", 32'(VIDEO_RESET_N), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("video_after_ready", 32'(VIDEO_RESET_N), 32'd1);

        // Reset pulse during VID_GAP restarts the full hold.
        guard = 0;
        while (m_state != 2 && guard < 100) begin step(1'b1, 1'b0, 1'b1, 1'b0); guard++; end
        chk("reach_vid_gap", 32'(SEQ_STATE), 32'd2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pulse_video_low", 32'(VIDEO_RESET_N), 32'd0);
        assert_cnt = 0; guard = 0;
        while (SEQ_STATE == 3'd0 && guard < 100) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            assert_cnt++; guard++;
        end
        chk("assert_repeat_clks", 32'(assert_cnt), 32'(H * TK));

        // Randomized inputs over many sequences, including occasional resets.
        rs = 1'b1; sr = 1'b0; rd = 1'b1; bz = 1'b0;
        for (int i = 0; i < 800; i++) begin
            rs = ($urandom_range(0, 79) != 0);
            sr = ($urandom_range(0, 11) == 0) ? ~sr : (sr & ($urandom_range(0, 3) != 0));
            rd = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) bz = ~bz;
            step(rs, sr, rd, bz);
        end

        // Illegal state code recovers to ASSERT on the next clock.
        guard = 0;
        while (m_state != 4 && guard < 200) begin step(1'b1, 1'b0, 1'b1, 1'b0); guard++; end
        chk("reach_run", 32'(SEQ_STATE), 32'd4);
        force dut.state_q = 3'd7;
        #1;
        release dut.state_q;
        m_state = 7;
        chk("forced_state", 32'(SEQ_STATE), 32'd7);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("illegal_recover_cpu", 32'(CPU_RESET_N), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
